// File: rtl/indirect_coe_sched_pkg.sv
// Shared constants and types for the indirect-coefficient scheduler.
// Coefficients are packed as {Ay_5..Ay_0, Ax_5..Ax_0}, with Ax_0 in the LSBs.
package indirect_coe_sched_pkg;

    localparam int ID_COE_BW         = 16;
    localparam int CLOUD_BW          = 16;
    localparam int ID_COE_LAT        = 5;
    localparam int ID_COE_FIFO_DEPTH = 8;
    localparam int ID_COE_PACK_BW    = 12 * ID_COE_BW;
    localparam int ID_COE_PTS_BW     = 19;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} id_sched_state_t;

endpackage

// File: rtl/coe_sync_fifo.sv
// Synchronous fall-through FIFO. The head word is visible whenever the FIFO is not empty.
// A write that arrives while the FIFO is full is accepted only if a read happens in the same cycle.
module coe_sync_fifo #(
    parameter int DATA_BW = 192,
    parameter int DEPTH   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr,
    input  logic [DATA_BW-1:0] i_wdata,
    input  logic               i_rd,
    output logic [DATA_BW-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BW = $clog2(DEPTH + 1);

    logic [DATA_BW-1:0] mem_q [DEPTH];
    logic [PTR_BW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_BW-1:0]  cnt_q;
    logic               do_wr, do_rd;

    function automatic logic [PTR_BW-1:0] ptr_inc(input logic [PTR_BW-1:0] p);
        return (p == PTR_BW'(DEPTH - 1)) ? '0 : p + PTR_BW'(1);
    endfunction

    assign o_full  = (cnt_q == CNT_BW'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign do_rd   = i_rd && !o_empty;
    assign do_wr   = i_wr && (!o_full || do_rd);
    assign o_rdata = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CNT_BW'(do_wr) - CNT_BW'(do_rd);
        end
    end

    // NOTE: storage has no reset; the count and pointers alone decide which words are valid.
    always_ff @(posedge i_clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/indirect_coe_sched.sv
// Credit-based issue/collect scheduler around the fixed-latency indirect-coefficient datapath.
// A point is issued only when a FIFO slot is reserved for its result.
module indirect_coe_sched
    import indirect_coe_sched_pkg::*;
#(
    parameter int DATA_BW = ID_COE_PACK_BW,
    parameter int LAT     = ID_COE_LAT,
    parameter int DEPTH   = ID_COE_FIFO_DEPTH,
    parameter int PTS_BW  = ID_COE_PTS_BW
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [PTS_BW-1:0]   i_num_pts,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [CLOUD_BW-1:0] i_cloud_x,
    input  logic [CLOUD_BW-1:0] i_cloud_y,
    input  logic [CLOUD_BW-1:0] i_cloud_z,
    output logic                o_coe_valid,
    output logic [CLOUD_BW-1:0] o_cloud_x,
    output logic [CLOUD_BW-1:0] o_cloud_y,
    output logic [CLOUD_BW-1:0] o_cloud_z,
    input  logic                i_coe_valid,
    input  logic [DATA_BW-1:0]  i_coe_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_BW-1:0]  o_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int CRED_BW = $clog2(DEPTH + 1);

    if (DEPTH < LAT + 2) begin : g_depth_chk
        $error("indirect_coe_sched: DEPTH must be at least LAT+2");
    end

    id_sched_state_t     state_q, state_d;
    logic [PTS_BW-1:0]   num_q, num_d, issued_q, issued_d, popped_q, popped_d;
    logic [CRED_BW-1:0]  cred_q, cred_d;
    logic                err_q, err_d;
    logic                coe_valid_q;
    logic [CLOUD_BW-1:0] cloud_x_q, cloud_y_q, cloud_z_q;
    logic                start_acc, issue, pop, overflow;
    logic                fifo_full, fifo_empty;
    logic [DATA_BW-1:0]  fifo_head;

    assign start_acc = (state_q == IDLE) && i_start;
    assign o_ready   = (state_q == RUN) && (cred_q < CRED_BW'(DEPTH)) && (issued_q < num_q);
    assign issue     = i_valid && o_ready;
    assign o_valid   = !fifo_empty;
    assign pop       = o_valid && i_ready;
    assign overflow  = i_coe_valid && fifo_full && !pop;

    // Gate the head so the data bus reads zero whenever nothing is valid, including after reset.
    assign o_data      = o_valid ? fifo_head : '0;
    assign o_coe_valid = coe_valid_q;
    assign o_cloud_x   = cloud_x_q;
    assign o_cloud_y   = cloud_y_q;
    assign o_cloud_z   = cloud_z_q;
    assign o_err       = err_q;

    coe_sync_fifo #(.DATA_BW(DATA_BW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr    (i_coe_valid),
        .i_wdata (i_coe_data),
        .i_rd    (pop),
        .o_rdata (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        num_d    = num_q;
        issued_d = issued_q + PTS_BW'(issue);
        popped_d = popped_q + PTS_BW'(pop);
        err_d    = err_q | overflow;
        cred_d   = cred_q;
        // Pops never take the credit below zero (only possible with externally forced results).
        if (issue && !(pop && cred_q != '0)) begin
            cred_d = cred_q + CRED_BW'(1);
        end else if (!issue && pop && cred_q != '0) begin
            cred_d = cred_q - CRED_BW'(1);
        end
        if (start_acc) begin
            num_d    = i_num_pts;
            issued_d = '0;
            popped_d = '0;
            err_d    = overflow;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = (i_num_pts != '0) ? RUN : DONE;
            RUN:     if (issued_d == num_q) state_d = DRAIN;
            DRAIN:   if (popped_d == num_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != IDLE);
        o_done = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            cred_q      <= '0;
            err_q       <= 1'b0;
            coe_valid_q <= 1'b0;
            cloud_x_q   <= '0;
            cloud_y_q   <= '0;
            cloud_z_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            cred_q      <= cred_d;
            err_q       <= err_d;
            coe_valid_q <= issue;
            if (issue) begin
                cloud_x_q <= i_cloud_x;
                cloud_y_q <= i_cloud_y;
                cloud_z_q <= i_cloud_z;
            end
        end
    end

endmodule

// File: tb/tb_indirect_coe_sched.sv
// Scoreboard bench for indirect_coe_sched with a behavioural LAT-cycle datapath in the loop.
// Accepted points push their expected coefficients; a negedge monitor pops and compares results.
module tb_indirect_coe_sched;
    import indirect_coe_sched_pkg::*;

    localparam int DW    = ID_COE_PACK_BW;
    localparam int LAT   = ID_COE_LAT;
    localparam int DEPTH = ID_COE_FIFO_DEPTH;
    localparam int PW    = ID_COE_PTS_BW;
    localparam int CW    = CLOUD_BW;

    logic          clk, rst_n;
    logic          i_start, i_valid, i_ready;
    logic [PW-1:0] i_num_pts;
    logic [CW-1:0] i_cloud_x, i_cloud_y, i_cloud_z;
    logic          o_ready, o_coe_valid, o_valid, o_busy, o_done, o_err;
    logic [CW-1:0] o_cloud_x, o_cloud_y, o_cloud_z;
    logic          i_coe_valid;
    logic [DW-1:0] i_coe_data, o_data;

    logic          force_mode, f_valid;
    logic [DW-1:0] f_data;

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_acc, n_pop, n_issue, n_done, cur_run, max_run, max_cred;
    int first_acc_cyc, first_val_cyc, pops_at_done;
    logic [DW-1:0] exp_q[$];

    indirect_coe_sched dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_pts(i_num_pts),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_cloud_x(i_cloud_x), .i_cloud_y(i_cloud_y), .i_cloud_z(i_cloud_z),
        .o_coe_valid(o_coe_valid),
        .o_cloud_x(o_cloud_x), .o_cloud_y(o_cloud_y), .o_cloud_z(o_cloud_z),
        .i_coe_valid(i_coe_valid), .i_coe_data(i_coe_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] dp_fn(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                            input logic [CW-1:0] z);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < 12; j++)
            r[j*ID_COE_BW +: ID_COE_BW] = ID_COE_BW'(x * (j + 1)) + y - z + ID_COE_BW'(j);
        return r;
    endfunction

    function automatic logic [DW-1:0] ov_word(input int j);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = 32'hC0DE_0000 + 32'(j * 16 + k);
        return r;
    endfunction

    // Datapath stand-in: o_coe_valid rises after edge A, i_coe_valid rises after edge A+LAT.
    logic          dp_v [LAT];
    logic [DW-1:0] dp_d [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) dp_v[i] <= 1'b0;
        end else begin
            dp_v[0] <= o_coe_valid;
            dp_d[0] <= dp_fn(o_cloud_x, o_cloud_y, o_cloud_z);
            for (int i = 1; i < LAT; i++) begin
                dp_v[i] <= dp_v[i-1];
                dp_d[i] <= dp_d[i-1];
            end
        end
    end
    assign i_coe_valid = force_mode ? f_valid : dp_v[LAT-1];
    assign i_coe_data  = force_mode ? f_data  : dp_d[LAT-1];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pushes expectations on accepts, pops and compares on every delivered result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_valid && o_ready) begin
                exp_q.push_back(dp_fn(i_cloud_x, i_cloud_y, i_cloud_z));
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                n_acc++;
            end
            if (o_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check_int("unexpected_result", 1, 0);
                else check("result_data", o_data, exp_q.pop_front());
                n_pop++;
            end
            if (o_coe_valid) begin
                n_issue++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (int'(dut.cred_q) > max_cred) max_cred = int'(dut.cred_q);
            if (o_done) begin
                n_done++;
                pops_at_done = n_pop;
            end
        end
    end

    task automatic clear_stats();
        n_acc = 0; n_pop = 0; n_issue = 0; n_done = 0; cur_run = 0; max_run = 0;
        max_cred = 0; first_acc_cyc = -1; first_val_cyc = -1; pops_at_done = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        i_num_pts = PW'(n);
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic send(input int base, input int count, input int budget, input bit toggle,
                        output int sent);
        bit acc;
        sent    = 0;
        i_valid = 1'b1;
        for (int c = 0; c < budget && sent < count; c++) begin
            i_cloud_x = CW'((base + sent) * 3 + 1);
            i_cloud_y = CW'((base + sent) * 7 + 2);
            i_cloud_z = CW'(32'hA5A5 ^ (base + sent));
            if (toggle) i_ready = ~i_ready;
            acc = o_ready;
            tick();
            if (acc) sent++;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (!(n_done > 0 && !o_busy) && c < budget) begin
            tick();
            c++;
        end
        check_int(name, int'(c < budget), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, sent2;
        rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_num_pts = '0;
        i_cloud_x = '0; i_cloud_y = '0; i_cloud_z = '0;
        force_mode = 1'b0; f_valid = 1'b0; f_data = '0;
        clear_stats();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check_int("rst_busy", int'(o_busy), 0);
        check_int("rst_ready", int'(o_ready), 0);
        check_int("rst_valid", int'(o_valid), 0);
        check_int("rst_coe_valid", int'(o_coe_valid), 0);
        check_int("rst_done_err", int'({o_done, o_err}), 0);

        // Zero-count frame goes straight to DONE.
        start_frame(0);
        check_int("zero_busy", int'(o_busy), 1);
        check_int("zero_done", int'(o_done), 1);
        tick();
        check_int("zero_idle", int'({o_busy, o_done}), 0);
        check_int("zero_no_issue", n_issue, 0);

        // Streaming: 16 points, downstream always ready.
        clear_stats();
        i_ready = 1'b1;
        start_frame(16);
        send(100, 16, 64, 1'b0, sent);
        check_int("stream_sent", sent, 16);
        wait_done("stream_done_in_time", 200);
        check_int("stream_issue_cnt", n_issue, 16);
        check_int("stream_back_to_back", max_run, 16);
        check_int("stream_first_latency", first_val_cyc - first_acc_cyc, LAT + 2);
        check_int("stream_pops", n_pop, 16);
        check_int("stream_done_once", n_done, 1);
        check_int("stream_done_after_last", pops_at_done, 16);
        check_int("stream_queue_empty", exp_q.size(), 0);

        // Backpressure: credits stop issue at DEPTH outstanding.
        clear_stats();
        i_ready = 1'b0;
        start_frame(20);
        send(200, 20, 30, 1'b0, sent);
        check_int("bp_accepts_before_stall", sent, DEPTH);
        check_int("bp_ready_low", int'(o_ready), 0);
        i_ready = 1'b1;
        send(200 + sent, 20 - sent, 200, 1'b0, sent2);
        check_int("bp_remaining", sent2, 20 - DEPTH);
        wait_done("bp_done_in_time", 200);
        check_int("bp_pops", n_pop, 20);
        check_int("bp_err", int'(o_err), 0);
        check_int("bp_max_cred", int'(max_cred <= DEPTH), 1);

        // Full FIFO with i_ready toggling every cycle.
        clear_stats();
        i_ready = 1'b0;
        start_frame(24);
        send(300, 24, 12, 1'b0, sent);
        repeat (LAT + 3) tick();
        check_int("sim_fifo_full", int'(dut.fifo_full), 1);
        send(300 + sent, 24 - sent, 300, 1'b1, sent2);
        check_int("sim_sent", sent + sent2, 24);
        i_ready = 1'b1;
        wait_done("sim_done_in_time", 200);
        check_int("sim_pops", n_pop, 24);
        check_int("sim_max_cred", int'(max_cred <= DEPTH), 1);
        check_int("sim_err", int'(o_err), 0);

        // Reset mid-frame with results in flight.
        clear_stats();
        i_ready = 1'b0;
        start_frame(10);
        send(400, 3, 10, 1'b0, sent);
        rst_n = 1'b0;
        #1;
        check_int("mrst_flags", int'({o_busy, o_ready, o_valid, o_coe_valid, o_done, o_err}), 0);
        check("mrst_cloud", DW'({o_cloud_x, o_cloud_y, o_cloud_z}), '0);
        check("mrst_data", o_data, '0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        i_ready = 1'b1;
        start_frame(4);
        send(500, 4, 40, 1'b0, sent);
        wait_done("mrst_done_in_time", 100);
        check_int("mrst_pops", n_pop, 4);
        check_int("mrst_issue", n_issue, 4);
        check_int("mrst_queue_empty", exp_q.size(), 0);

        // Forced overflow: nine writes into an eight-entry FIFO with no pops.
        clear_stats();
        i_ready    = 1'b0;
        force_mode = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) begin
            f_valid = 1'b1;
            f_data  = ov_word(j);
            if (j < DEPTH) exp_q.push_back(ov_word(j));
            tick();
        end
        f_valid = 1'b0;
        check_int("ovf_err_set", int'(o_err), 1);
        start_frame(0);
        check_int("ovf_err_cleared", int'(o_err), 0);
        tick();
        force_mode = 1'b0;
        i_ready    = 1'b1;
        repeat (DEPTH + 4) tick();
        check_int("ovf_pops", n_pop, DEPTH);
        check_int("ovf_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
